// File: rtl/inner_product_arbiter.sv
// rtl/inner_product_arbiter.sv - two-requester round-robin arbiter around a shared multiply-accumulate dot-product engine
module inner_product_arbiter #(
    parameter int WIDTH = 32,
    parameter int LEN   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       in_valid,
    output logic [1:0]       in_ready,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] res,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_id_q, res_id_d;

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] acc_sum;
    logic             winner;

    // Product and sum are kept at WIDTH bits so the accumulator wraps silently.
    assign a_sel   = owner_q ? a1 : a0;
    assign b_sel   = owner_q ? b1 : b0;
    assign prod    = a_sel * b_sel;
    assign acc_sum = acc_q + prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            acc_q        <= '0;
            cnt_q        <= 8'd0;
            res_q        <= '0;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            res_id_q     <= res_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        res_id_d     = res_id_q;
        in_ready     = 2'b00;
        res_valid    = 1'b0;
        winner       = req[~last_owner_q] ? ~last_owner_q : last_owner_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    owner_d = winner;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // req is deliberately ignored here: the owner keeps the grant until the result is taken.
                in_ready[owner_q] = 1'b1;
                if (in_valid[owner_q]) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        res_d    = acc_sum;
                        res_id_d = owner_q;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    last_owner_d = owner_q;
                    gnt_d        = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    assign gnt    = gnt_q;
    assign res    = res_q;
    assign res_id = res_id_q;

endmodule

// File: tb/tb_inner_product_arbiter.sv
// tb/tb_inner_product_arbiter.sv - self-checking bench for inner_product_arbiter (WIDTH=32, LEN=3)
module tb_inner_product_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  gnt;
    logic [31:0] res;
    logic        res_id;
    logic        res_valid;
    logic        res_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
    } exp_t;

    typedef struct packed {
        logic [1:0]       req;
        logic             id;
        logic [0:2][31:0] a;
        logic [0:2][31:0] b;
        logic [31:0]      exp_res;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    inner_product_arbiter #(.WIDTH(32), .LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gnt       (gnt),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every completed result handshake; also watch for a double grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            check("gnt_never_both", 32'(gnt == 2'b11), 32'd0);
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(res_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_res", res, e.res);
                    check("sb_res_id", 32'(res_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_res"}, res, 32'd0);
        check({tag, "_res_id"}, 32'(res_id), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    endtask

    task automatic wait_grant(input logic id);
        logic [1:0] want;
        bit         ok;
        want = id ? 2'b10 : 2'b01;
        ok   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt == want) begin
                ok = 1;
                break;
            end
        end
        check("grant", 32'(gnt), 32'(want));
        if (ok) check("in_ready_busy", 32'(in_ready), 32'(want));
        tick();
    endtask

    task automatic do_beat(input logic id, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 0;
        if (id) begin
            a1 = a;
            b1 = b;
        end else begin
            a0 = a;
            b0 = b;
        end
        in_valid[id] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[id]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("beat_accept", 32'(in_ready[id]), 32'd1);
        tick();
        in_valid[id] = 1'b0;
    endtask

    task automatic finish_done(input logic id);
        logic [1:0] want;
        want = id ? 2'b10 : 2'b01;
        @(negedge clk);
        check("done_latency_res_valid", 32'(res_valid), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("done_gnt", 32'(gnt), 32'(want));
        tick();
        @(negedge clk);
        check("idle_res_valid", 32'(res_valid), 32'd0);
        check("idle_gnt", 32'(gnt), 32'd0);
        tick();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        req = 2'b00;
        in_valid = 2'b00;
        tick();
        check_outputs_zero("reset");
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        req = 2'b00;
        in_valid = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        res_ready = 1'b1;

        vecs[0] = '{req: 2'b01, id: 1'b0, a: {32'd1, 32'd2, 32'd3},        b: {32'd4, 32'd5, 32'd6},       exp_res: 32'd32};
        vecs[1] = '{req: 2'b01, id: 1'b0, a: {32'hFFFF_FFFF, 32'd1, 32'd0}, b: {32'd1, 32'd1, 32'd0},       exp_res: 32'd0};
        vecs[2] = '{req: 2'b10, id: 1'b1, a: {32'd7, 32'd9, 32'd11},       b: {32'd8, 32'd10, 32'd12},     exp_res: 32'd278};
        vecs[3] = '{req: 2'b10, id: 1'b1, a: {32'h0001_0000, 32'd2, 32'd5}, b: {32'h0001_0000, 32'd3, 32'd5}, exp_res: 32'd31};
        vecs[4] = '{req: 2'b01, id: 1'b0, a: {32'd0, 32'd0, 32'd4},        b: {32'd5, 32'd0, 32'd4},       exp_res: 32'd16};

        reset_dut();

        // Table-driven single-requester vectors; req is dropped right after the grant.
        for (int v = 0; v < 5; v++) begin
            req = vecs[v].req;
            wait_grant(vecs[v].id);
            req = 2'b00;
            sb.push_back('{id: vecs[v].id, res: vecs[v].exp_res});
            for (int k = 0; k < 3; k++) do_beat(vecs[v].id, vecs[v].a[k], vecs[v].b[k]);
            finish_done(vecs[v].id);
        end

        // Contention from reset: 0, then 1, then 0.
        reset_dut();
        req = 2'b11;
        wait_grant(1'b0);
        sb.push_back('{id: 1'b0, res: 32'd6});
        for (int k = 0; k < 3; k++) do_beat(1'b0, 32'd1, 32'd2);
        finish_done(1'b0);
        wait_grant(1'b1);
        sb.push_back('{id: 1'b1, res: 32'd12});
        for (int k = 0; k < 3; k++) do_beat(1'b1, 32'd2, 32'd2);
        finish_done(1'b1);
        wait_grant(1'b0);
        req = 2'b00;
        sb.push_back('{id: 1'b0, res: 32'd27});
        for (int k = 0; k < 3; k++) do_beat(1'b0, 32'd3, 32'd3);
        finish_done(1'b0);

        // Bubbles and result backpressure.
        req = 2'b01;
        wait_grant(1'b0);
        req = 2'b00;
        sb.push_back('{id: 1'b0, res: 32'd68});
        do_beat(1'b0, 32'd2, 32'd3);
        tick();
        do_beat(1'b0, 32'd4, 32'd5);
        tick();
        res_ready = 1'b0;
        do_beat(1'b0, 32'd6, 32'd7);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res", res, 32'd68);
            check("hold_res_id", 32'(res_id), 32'd0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("bp_release_res_valid", 32'(res_valid), 32'd0);
        tick();

        // Owner drops req after one beat; grant must persist.
        req = 2'b10;
        wait_grant(1'b1);
        sb.push_back('{id: 1'b1, res: 32'd63});
        do_beat(1'b1, 32'd4, 32'd5);
        req = 2'b00;
        @(negedge clk);
        check("drop_gnt_held", 32'(gnt), 32'h2);
        check("drop_in_ready", 32'(in_ready), 32'h2);
        tick();
        do_beat(1'b1, 32'd6, 32'd7);
        do_beat(1'b1, 32'd1, 32'd1);
        finish_done(1'b1);

        // Reset mid-vector: outputs clear immediately, no result appears.
        req = 2'b01;
        wait_grant(1'b0);
        req = 2'b00;
        do_beat(1'b0, 32'd5, 32'd5);
        do_beat(1'b0, 32'd5, 32'd5);
        rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick();
        rst = 1'b1;
        tick();
        req = 2'b01;
        wait_grant(1'b0);
        req = 2'b00;
        sb.push_back('{id: 1'b0, res: 32'd3});
        for (int k = 0; k < 3; k++) do_beat(1'b0, 32'd1, 32'd1);
        finish_done(1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
